led_mode_sequencer: RTL and testbench

//  Sequences the 4-LED status bank through selectable display modes: binary count,

---
 rtl/led_mode_sequencer_if.sv | 14 +
 rtl/led_mode_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_led_mode_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/led_mode_sequencer_if.sv
`default_nettype none
//==============================================================================
// led_mode_sequencer_if : raw button in, LED / mode / tick out.  Rev 1.0
//==============================================================================
interface led_mode_sequencer_if;
  logic       btn;
  logic [3:0] led;
  logic [1:0] mode;
  logic       tick;

  modport master (output btn, input led, mode, tick);
  modport slave  (input btn, output led, mode, tick);
endinterface
`default_nettype wire

// File: rtl/led_mode_sequencer.sv
`default_nettype none
//==============================================================================
// led_mode_sequencer : 4-LED pattern sequencer, button-selected modes.  Rev 1.0
// Optional: define LED_SEQ_FADE_EN to add the PWM FADE mode.
//==============================================================================
module led_mode_sequencer #(
  parameter int TICK_DIV        = 6000000,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int PWM_BITS        = 4
) (
  input  logic                clk,
  input  logic                rst,
  led_mode_sequencer_if.slave bus
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] c_tick_last = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] c_deb_last  = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] c_count = 2'd0;
  localparam logic [1:0] c_scan  = 2'd1;
  localparam logic [1:0] c_blink = 2'd2;
  localparam logic [1:0] c_fade  = 2'd3;
`ifdef LED_SEQ_FADE_EN
  localparam logic [1:0] c_last_mode = c_fade;
`else
  localparam logic [1:0] c_last_mode = c_blink;
`endif

  logic [1:0]    r_sync;
  logic          r_acc;
  logic [DW-1:0] r_deb_cnt;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_mode;
  logic [1:0]    w_mode_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    r_scan;
  logic          r_left;
  logic          r_blink;
  logic [3:0]    r_led;
  logic [3:0]    w_led_nxt;
  logic [3:0]    w_fade_led;
  logic          w_press;
  logic          w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync    <= 2'b00;
      r_acc     <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync <= {r_sync[0], bus.btn};
      if (r_sync[1] != r_acc) begin
        if (r_deb_cnt == c_deb_last) begin
          r_acc     <= r_sync[1];
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= r_deb_cnt + DW'(1);
        end
      end else begin
        r_deb_cnt <= '0;
      end
    end
  end

  // Press fires in the same cycle the accepted level flips 0->1.
  assign w_press = (r_sync[1] != r_acc) && (r_deb_cnt == c_deb_last) && r_sync[1];
  assign w_tick  = (r_presc == c_tick_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_press || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode <= c_count;
    end else begin
      r_mode <= w_mode_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    if (w_press) begin
      w_mode_nxt = (r_mode == c_last_mode) ? c_count : r_mode + 2'd1;
    end
  end

  // A press reloads every pattern's entry state; a coincident tick is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || w_press) begin
      r_cnt   <= 4'd0;
      r_scan  <= 4'b0001;
      r_left  <= 1'b1;
      r_blink <= 1'b0;
    end else if (w_tick) begin
      case (r_mode)
        c_count: r_cnt <= r_cnt + 4'd1;
        c_scan: begin
          if (r_left && r_scan[3]) begin
            r_scan <= r_scan >> 1;
            r_left <= 1'b0;
          end else if (!r_left && r_scan[0]) begin
            r_scan <= r_scan << 1;
            r_left <= 1'b1;
          end else if (r_left) begin
            r_scan <= r_scan << 1;
          end else begin
            r_scan <= r_scan >> 1;
          end
        end
        c_blink: r_blink <= ~r_blink;
        default: ;
      endcase
    end
  end

`ifdef LED_SEQ_FADE_EN
  localparam logic [PWM_BITS-1:0] c_duty_max = '1;

  logic [PWM_BITS-1:0] r_pwm;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_up;

  // The ramp holds each end value for one extra step before reversing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm  <= '0;
      r_duty <= '0;
      r_up   <= 1'b1;
    end else begin
      r_pwm <= r_pwm + PWM_BITS'(1);
      if (w_press) begin
        r_duty <= '0;
        r_up   <= 1'b1;
      end else if (w_tick && (r_mode == c_fade)) begin
        if (r_up) begin
          if (r_duty == c_duty_max) r_up <= 1'b0;
          else                      r_duty <= r_duty + PWM_BITS'(1);
        end else begin
          if (r_duty == '0) r_up <= 1'b1;
          else              r_duty <= r_duty - PWM_BITS'(1);
        end
      end
    end
  end

  assign w_fade_led = (r_pwm < r_duty) ? 4'b1111 : 4'b0000;
`else
  logic [PWM_BITS-1:0] w_unused_pwm;
  assign w_unused_pwm = '0;
  assign w_fade_led   = 4'b0000;
`endif

  always_comb begin
    w_led_nxt = 4'b0000;
    case (r_mode)
      c_count: w_led_nxt = r_cnt;
      c_scan:  w_led_nxt = r_scan;
      c_blink: w_led_nxt = {4{r_blink}};
      c_fade:  w_led_nxt = w_fade_led;
      default: w_led_nxt = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led <= 4'b0000;
    end else begin
      r_led <= w_led_nxt;
    end
  end

  assign bus.led  = r_led;
  assign bus.mode = r_mode;
  assign bus.tick = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_led_mode_sequencer.sv
`default_nettype none
//==============================================================================
// tb_led_mode_sequencer : randomized button stimulus against a pattern-table model.  Rev 1.0
//==============================================================================
module tb_led_mode_sequencer;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int PB = 2;
`ifdef LED_SEQ_FADE_EN
  localparam int NM = 4;
`else
  localparam int NM = 3;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  led_mode_sequencer_if bus ();

  led_mode_sequencer #(
    .TICK_DIV        (TD),
    .DEBOUNCE_CYCLES (DB),
    .PWM_BITS        (PB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Model state: the pattern is a pure function of mode and steps since entry.
  int         m_presc, m_k, m_run, m_pwm;
  int         m_press_on_tick = 0;
  logic [1:0] m_mode;
  logic       m_s1, m_s2, m_acc, m_tick, m_press;
  logic [3:0] m_led;
  logic [6:0] exp_q[$];

  function automatic logic [3:0] pattern(int mode, int k, int pwm);
    int n, i, duty;
    case (mode)
      0: return 4'(k % 16);
      1: case (k % 6)
           0: return 4'b0001;
           1: return 4'b0010;
           2: return 4'b0100;
           3: return 4'b1000;
           4: return 4'b0100;
           default: return 4'b0010;
         endcase
      2: return (k % 2 == 1) ? 4'b1111 : 4'b0000;
      default: begin
        n    = 1 << PB;
        i    = k % (2 * n);
        duty = (i < n) ? i : 2 * n - 1 - i;
        return (pwm < duty) ? 4'b1111 : 4'b0000;
      end
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_presc = 0; m_k = 0; m_run = 0; m_pwm = 0;
      m_mode = 2'd0; m_s1 = 1'b0; m_s2 = 1'b0; m_acc = 1'b0; m_led = 4'b0000;
    end else begin
      m_tick  = (m_presc == TD - 1);
      m_press = 1'b0;
      if (m_s2 != m_acc) begin
        m_run++;
        if (m_run == DB) begin
          m_acc   = m_s2;
          m_run   = 0;
          m_press = m_acc;
        end
      end else begin
        m_run = 0;
      end
      m_led = pattern(int'(m_mode), m_k, m_pwm);
      if (m_press) begin
        if (m_tick) m_press_on_tick++;
        m_mode  = 2'((int'(m_mode) + 1) % NM);
        m_k     = 0;
        m_presc = 0;
      end else if (m_tick) begin
        m_k++;
        m_presc = 0;
      end else begin
        m_presc++;
      end
      m_pwm = (m_pwm + 1) % (1 << PB);
      m_s2  = m_s1;
      m_s1  = bus.btn;
    end
    exp_q.push_back({m_led, m_mode, 1'(m_presc == TD - 1)});
  end

  always @(negedge clk) begin
    logic [6:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.led, bus.mode, bus.tick} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got led=%b mode=%0d tick=%b, expected led=%b mode=%0d tick=%b",
                 $time, bus.led, bus.mode, bus.tick, e[6:3], e[2:1], e[0]);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int n);
    bus.btn = 1'b1;
    cyc(n);
    bus.btn = 1'b0;
  endtask

  // Press lands five edges after the button rises; start it so that edge is a tick.
  task automatic press_on_tick();
    int target;
    target = ((TD - 1 - 4) % TD + TD) % TD;
    cyc(DB + 6);
    for (int n = 0; n < 4 * TD && m_presc != target; n++) cyc(1);
    pulse(6);
    cyc(12);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.btn = 1'b0;
    rst     = 1'b1;
    cyc(3);
    check("reset_led",  8'(bus.led),  8'h0);
    check("reset_mode", 8'(bus.mode), 8'h0);
    check("reset_tick", 8'(bus.tick), 8'h0);
    rst = 1'b0;

    cyc(20);
    pulse(2);
    cyc(10);
    pulse(6);
    cyc(30);
    for (int i = 0; i < 4; i++) begin
      pulse(6);
      cyc(4 * TD * 3);
    end

    repeat (40) begin
      pulse($urandom_range(1, 8));
      cyc($urandom_range(1, 40));
    end

    press_on_tick();
    press_on_tick();

    cyc(10);
    for (int n = 0; n < 8 && m_mode != 2'(NM - 1); n++) begin
      pulse(6);
      cyc(10);
    end
    cyc(20);
    rst = 1'b1;
    #1;
    check("midrun_reset_led",  8'(bus.led),  8'h0);
    check("midrun_reset_mode", 8'(bus.mode), 8'h0);
    check("midrun_reset_tick", 8'(bus.tick), 8'h0);
    cyc(2);
    rst = 1'b0;
    cyc(20);
    pulse(6);
    cyc(20);

    check("press_on_tick_seen", 8'(m_press_on_tick > 0), 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
